// File: rtl/pkt_mem_if.sv
// pkt_mem_if: signal bundle for the packet memory.
//
// Groups the word-wide bus port and the byte-stream loader port.
//   master modport: the side that issues bus accesses and streams packet bytes.
//   slave  modport: the packet memory itself.
//
// Handshake: a loader byte moves on a rising edge where ld_valid_i and
// ld_ready_o are both 1. ld_data_i and ld_last_i must be stable while
// ld_valid_i is 1. ld_ready_o depends only on loader state, never on ld_valid_i.
// The bus port has no handshake: every access with sram_ce_i = 1 is taken.
//
// ld_state is a debug view of the loader FSM:
//   0 = L_IDLE, 1 = L_COLLECT, 2 = L_FLUSH, 3 = L_DONE.
interface pkt_mem_if;
    // bus port
    logic        sram_ce_i;
    logic        sram_we_i;
    logic [31:0] sram_addr_i;
    logic [3:0]  sram_sel_i;
    logic [31:0] sram_data_i;
    logic [31:0] sram_data_o;
    logic        sram_err_o;
    // loader port
    logic        ld_start_i;
    logic [31:0] ld_base_i;
    logic        ld_valid_i;
    logic [7:0]  ld_data_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic [15:0] ld_len_o;
    // debug
    logic [1:0]  ld_state;

    modport master (
        output sram_ce_i, sram_we_i, sram_addr_i, sram_sel_i, sram_data_i,
        output ld_start_i, ld_base_i, ld_valid_i, ld_data_i, ld_last_i,
        input  sram_data_o, sram_err_o,
        input  ld_ready_o, ld_done_o, ld_len_o, ld_state
    );

    modport slave (
        input  sram_ce_i, sram_we_i, sram_addr_i, sram_sel_i, sram_data_i,
        input  ld_start_i, ld_base_i, ld_valid_i, ld_data_i, ld_last_i,
        output sram_data_o, sram_err_o,
        output ld_ready_o, ld_done_o, ld_len_o, ld_state
    );
endinterface

// File: rtl/pkt_mem.sv
// pkt_mem: single-ported word memory shared by a bus responder and a
// packet loader.
//
// Ports:
//   clk  - clock, everything on the rising edge
//   rst  - synchronous active-high reset (memory contents are kept)
//   bus  - pkt_mem_if.slave:
//          bus port    : fixed one-cycle read latency, byte-lane writes,
//                        sram_err_o pulses for accesses past DEPTH words
//          loader port : packs a big-endian byte stream into 32-bit words
//                        starting at ld_base_i and writes them to memory,
//                        reports completion with ld_done_o / ld_len_o
//
// The bus always wins the memory: the loader only writes a packed word in a
// cycle with no bus access, so the two never collide.
module pkt_mem #(
    parameter int DEPTH = 256
) (
    input  logic      clk,
    input  logic      rst,
    pkt_mem_if.slave  bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        L_IDLE    = 2'd0,
        L_COLLECT = 2'd1,
        L_FLUSH   = 2'd2,
        L_DONE    = 2'd3
    } ld_state_t;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [29:0] bus_idx;
    logic        bus_in_range;
    logic        bus_rd;
    logic        bus_wr;

    assign bus_idx      = bus.sram_addr_i[31:2];
    assign bus_in_range = (bus_idx < DEPTH_W);
    assign bus_rd       = bus.sram_ce_i && !bus.sram_we_i;
    assign bus_wr       = bus.sram_ce_i && bus.sram_we_i && bus_in_range;

    // Byte-offset bits of both addresses carry no meaning.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.sram_addr_i[1:0], bus.ld_base_i[1:0]};

    // ------------------------------------------------------------------
    // Loader state and datapath registers
    // ------------------------------------------------------------------
    ld_state_t   state;
    ld_state_t   state_next;
    logic [29:0] wptr;
    logic [15:0] count;
    logic [1:0]  lane;
    logic [31:0] buf_data;
    logic [3:0]  buf_sel;
    logic        last_seen;
    logic [15:0] len_q;

    logic        ld_ready;
    logic        ld_done;
    logic        accept;
    logic        flush_go;
    logic        ld_wr;
    logic [1:0]  lane_pos;

    // lane 0 is the most significant byte, so it maps to sel bit 3
    assign lane_pos = 2'd3 - lane;
    assign accept   = (state == L_COLLECT) && bus.ld_valid_i;
    assign flush_go = (state == L_FLUSH) && !bus.sram_ce_i;
    // words past the end of memory are dropped silently; the bus error
    // flag is reserved for bus accesses
    assign ld_wr    = flush_go && (wptr < DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= L_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        case (state)
            L_IDLE: begin
                if (bus.ld_start_i) begin
                    state_next = L_COLLECT;
                end
            end
            L_COLLECT: begin
                ld_ready = 1'b1;
                if (accept && ((lane == 2'd3) || bus.ld_last_i)) begin
                    state_next = L_FLUSH;
                end
            end
            L_FLUSH: begin
                if (!bus.sram_ce_i) begin
                    state_next = last_seen ? L_DONE : L_COLLECT;
                end
            end
            L_DONE: begin
                ld_done    = 1'b1;
                state_next = L_IDLE;
            end
            default: begin
                state_next = L_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            count     <= '0;
            lane      <= '0;
            buf_data  <= '0;
            buf_sel   <= '0;
            last_seen <= 1'b0;
            len_q     <= '0;
        end else begin
            case (state)
                L_IDLE: begin
                    if (bus.ld_start_i) begin
                        wptr      <= bus.ld_base_i[31:2];
                        count     <= '0;
                        lane      <= '0;
                        buf_data  <= '0;
                        buf_sel   <= '0;
                        last_seen <= 1'b0;
                    end
                end
                L_COLLECT: begin
                    if (accept) begin
                        buf_data[{lane_pos, 3'b000} +: 8] <= bus.ld_data_i;
                        buf_sel[lane_pos]                 <= 1'b1;
                        lane                              <= lane + 2'd1;
                        last_seen                         <= bus.ld_last_i;
                        if (count != 16'hFFFF) begin
                            count <= count + 16'd1;
                        end
                    end
                end
                L_FLUSH: begin
                    // wptr wraps at 2^30 naturally from its width
                    if (flush_go) begin
                        wptr     <= wptr + 30'd1;
                        buf_data <= '0;
                        buf_sel  <= '0;
                        lane     <= '0;
                    end
                end
                L_DONE: begin
                    len_q <= count;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory array: no reset, so a reset mid-load keeps flushed words.
    // Bus and loader writes are mutually exclusive by construction
    // (the loader only writes when sram_ce_i is 0).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sram_sel_i[b]) begin
                    mem[bus_idx[AW-1:0]][b*8 +: 8] <= bus.sram_data_i[b*8 +: 8];
                end
            end
        end else if (ld_wr && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (buf_sel[b]) begin
                    mem[wptr[AW-1:0]][b*8 +: 8] <= buf_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus response: read data and error flag are registered, so they
    // appear in the cycle after the access is sampled. Read data holds
    // through writes and idle cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sram_data_o <= '0;
            bus.sram_err_o  <= 1'b0;
        end else begin
            bus.sram_err_o <= bus.sram_ce_i && !bus_in_range;
            if (bus_rd) begin
                bus.sram_data_o <= bus_in_range ? mem[bus_idx[AW-1:0]] : 32'h0000_0000;
            end
        end
    end

    assign bus.ld_ready_o = ld_ready;
    assign bus.ld_done_o  = ld_done;
    assign bus.ld_len_o   = len_q;
    assign bus.ld_state   = state;

endmodule
